jhash_mix_stage: RTL and testbench

- One step of the Bob Jenkins lookup3 "mix" round for the jhash engine: x -= z; x ^= rotl(z, k); z += y on three 32-bit words.
- The caller registers a/b/c and feeds the outputs back rotated: a <= OB, b <= OC, c <= OA. Six consecutive steps with k = 4, 6, 8, 16, 19, 4 form one full lookup3 mix.
- Pure datapath with no handshake. The output register is optional.

---
 rtl/jhash_mix_stage_if.sv | 13 +
 rtl/jhash_mix_stage.sv | 44 ++++
 tb/tb_jhash_mix_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/jhash_mix_stage_if.sv
// jhash_mix_stage_if: word bus for one lookup3 mix step.
// The master supplies the three words and the rotate amount; the slave returns the mixed words.
interface jhash_mix_stage_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [4:0]  shift;
    logic [31:0] OA;
    logic [31:0] OB;
    logic [31:0] OC;
    modport master (output a, b, c, shift, input OA, OB, OC);
    modport slave  (input a, b, c, shift, output OA, OB, OC);
endinterface

// File: rtl/jhash_mix_stage.sv
// jhash_mix_stage: one lookup3 mix step, x -= z; x ^= rotl(z, k); z += y.
// OUT_REG selects a zero-latency combinational path or a one-cycle registered path.
module jhash_mix_stage #(
    parameter bit OUT_REG = 1'b0
) (
    input logic               clk,
    input logic               rst,
    jhash_mix_stage_if.slave  bus
);
    logic [31:0] w_rot;
    logic [31:0] w_oa;
    logic [31:0] w_oc;
    // A shift of 32 yields zero, so k = 0 collapses to c itself.
    assign w_rot = (bus.c << bus.shift) | (bus.c >> (6'd32 - {1'b0, bus.shift}));
    assign w_oa  = (bus.a - bus.c) ^ w_rot;
    assign w_oc  = bus.c + bus.b;
    generate
        if (OUT_REG) begin : g_reg
            logic [31:0] r_oa;
            logic [31:0] r_ob;
            logic [31:0] r_oc;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_oa <= '0;
                    r_ob <= '0;
                    r_oc <= '0;
                end else begin
                    r_oa <= w_oa;
                    r_ob <= bus.b;
                    r_oc <= w_oc;
                end
            end
            assign bus.OA = r_oa;
            assign bus.OB = r_ob;
            assign bus.OC = r_oc;
        end else begin : g_comb
            logic w_unused;
            assign w_unused = ^{clk, rst};
            assign bus.OA   = w_oa;
            assign bus.OB   = bus.b;
            assign bus.OC   = w_oc;
        end
    endgenerate
endmodule

// File: tb/tb_jhash_mix_stage.sv
// tb_jhash_mix_stage: directed checks of the combinational and registered mix step,
// plus a six-step feedback chain against a software lookup3 mix.
module tb_jhash_mix_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    jhash_mix_stage_if if_c ();
    jhash_mix_stage_if if_r ();

    jhash_mix_stage #(.OUT_REG(1'b0)) u_comb (.clk(clk), .rst(rst), .bus(if_c));
    jhash_mix_stage #(.OUT_REG(1'b1)) u_reg  (.clk(clk), .rst(rst), .bus(if_r));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [4:0] s);
        if_c.a = a; if_c.b = b; if_c.c = c; if_c.shift = s;
        if_r.a = a; if_r.b = b; if_r.c = c; if_r.shift = s;
    endtask

    function automatic logic [31:0] rot(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    task automatic sw_mix(inout logic [31:0] a, inout logic [31:0] b, inout logic [31:0] c);
        a -= c; a ^= rot(c, 4);  c += b;
        b -= a; b ^= rot(a, 6);  a += c;
        c -= b; c ^= rot(b, 8);  b += a;
        a -= c; a ^= rot(c, 16); c += b;
        b -= a; b ^= rot(a, 19); a += c;
        c -= b; c ^= rot(b, 4);  b += a;
    endtask

    initial begin
        logic [31:0] ra, rb, rc, ea, eb, ec;
        logic [4:0]  ks [6];
        ks = '{5'd4, 5'd6, 5'd8, 5'd16, 5'd19, 5'd4};
        drive(32'd1, 32'd2, 32'd3, 5'd4);
        #1;
        check("reg_reset_oa", if_r.OA, 32'h0);
        check("reg_reset_ob", if_r.OB, 32'h0);
        check("reg_reset_oc", if_r.OC, 32'h0);
        check("t1_oa", if_c.OA, 32'hFFFFFFCE);
        check("t1_ob", if_c.OB, 32'h00000002);
        check("t1_oc", if_c.OC, 32'h00000005);
        drive(32'h10, 32'h7FFFFFFF, 32'h80000001, 5'd4);
        #1;
        check("t2_oa", if_c.OA, 32'h80000017);
        check("t2_ob", if_c.OB, 32'h7FFFFFFF);
        check("t2_oc", if_c.OC, 32'h00000000);
        drive(32'd5, 32'd0, 32'd3, 5'd0);
        #1;
        check("rot0_oa", if_c.OA, 32'h00000001);
        check("rot0_oc", if_c.OC, 32'h00000003);
        drive(32'd0, 32'd0, 32'd1, 5'd31);
        #1;
        check("rot31_oa", if_c.OA, 32'h7FFFFFFF);
        drive(32'h12345678, 32'd0, 32'h12345678, 5'd16);
        #1;
        check("rot16_oa", if_c.OA, 32'h56781234);
        check("rot16_oc", if_c.OC, 32'h12345678);
        drive(32'd0, 32'd0, 32'd0, 5'd13);
        #1;
        check("zero_oa", if_c.OA, 32'h0);
        check("zero_ob", if_c.OB, 32'h0);
        check("zero_oc", if_c.OC, 32'h0);
        drive(32'd1, 32'd2, 32'd3, 5'd4);
        @(posedge clk); #1;
        check("reg_held_rst_oa", if_r.OA, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("reg_load_oa", if_r.OA, 32'hFFFFFFCE);
        check("reg_load_ob", if_r.OB, 32'h00000002);
        check("reg_load_oc", if_r.OC, 32'h00000005);
        @(negedge clk); rst = 1'b1;
        #1;
        check("reg_async_oa", if_r.OA, 32'h0);
        check("reg_async_ob", if_r.OB, 32'h0);
        check("reg_async_oc", if_r.OC, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("reg_reload_oa", if_r.OA, 32'hFFFFFFCE);
        @(negedge clk);
        drive(32'h10, 32'h7FFFFFFF, 32'h80000001, 5'd4);
        #1;
        check("reg_hold_oa", if_r.OA, 32'hFFFFFFCE);
        check("reg_hold_ob", if_r.OB, 32'h00000002);
        check("reg_hold_oc", if_r.OC, 32'h00000005);
        @(posedge clk); #1;
        check("reg_next_oa", if_r.OA, 32'h80000017);
        check("reg_next_ob", if_r.OB, 32'h7FFFFFFF);
        check("reg_next_oc", if_r.OC, 32'h00000000);
        ra = 32'hDEADBEF0; rb = 32'hDEADBEEF; rc = 32'hDEADBEEF;
        ea = ra; eb = rb; ec = rc;
        sw_mix(ea, eb, ec);
        for (int i = 0; i < 6; i++) begin
            drive(ra, rb, rc, ks[i]);
            #1;
            ra = if_c.OB; rb = if_c.OC; rc = if_c.OA;
        end
        check("chain_a", ra, ea);
        check("chain_b", rb, eb);
        check("chain_c", rc, ec);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
